// File: rtl/join_sync_param_if.sv
// Handshake bundle for join_sync_param: producer channels, the consumer channel and status.
// The join itself uses the slave view; the surrounding pipeline or a bench uses the master view.
interface join_sync_param_if #(
  parameter int SIZE      = 2,
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
);
  logic [SIZE-1:0]       mask;
  logic [SIZE-1:0]       req_in;
  logic [SIZE*WIDTH-1:0] data_in;
  logic [SIZE-1:0]       ack_in;
  logic                  req_out;
  logic [SIZE*WIDTH-1:0] data_out;
  logic                  ack_out;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  count;

  modport master (
    output mask, req_in, data_in, ack_out,
    input  ack_in, req_out, data_out, busy, count
  );

  modport slave (
    input  mask, req_in, data_in, ack_out,
    output ack_in, req_out, data_out, busy, count
  );
endinterface

// File: rtl/join_sync_param.sv
// N-way 4-phase join: waits for every enabled producer request, issues one bundled request
// to the consumer, completes return-to-zero on both sides and counts finished transactions.
module join_sync_param #(
  parameter int SIZE        = 2,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic              clk,
  input  logic              rst,
  join_sync_param_if.slave  bus
);
  localparam int DW = SIZE * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RTZ  = 2'b10,
    BAD  = 2'b11
  } state_t;

  logic [SIZE-1:0] req_s;
  logic            ack_s;

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign req_s = bus.req_in;
      assign ack_s = bus.ack_out;
    end else begin : g_sync
      logic [SIZE-1:0]        req_sync_q [SYNC_STAGES];
      logic [SIZE-1:0]        req_sync_d [SYNC_STAGES];
      logic [SYNC_STAGES-1:0] ack_sync_q;
      logic [SYNC_STAGES-1:0] ack_sync_d;

      always_comb begin
        req_sync_d[0] = bus.req_in;
        ack_sync_d    = ack_sync_q;
        ack_sync_d[0] = bus.ack_out;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          req_sync_d[i] = req_sync_q[i-1];
          ack_sync_d[i] = ack_sync_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int i = 0; i < SYNC_STAGES; i++) begin
            req_sync_q[i] <= '0;
          end
          ack_sync_q <= '0;
        end else begin
          req_sync_q <= req_sync_d;
          ack_sync_q <= ack_sync_d;
        end
      end

      assign req_s = req_sync_q[SYNC_STAGES-1];
      assign ack_s = ack_sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Disabled channels contribute zeros to the captured word.
  logic [DW-1:0] data_masked;
  for (genvar gi = 0; gi < SIZE; gi++) begin : g_mask
    assign data_masked[gi*WIDTH +: WIDTH] =
      bus.mask[gi] ? bus.data_in[gi*WIDTH +: WIDTH] : '0;
  end

  state_t               state_q, state_d;
  logic [SIZE-1:0]      mask_q, mask_d;
  logic [SIZE-1:0]      ack_in_q, ack_in_d;
  logic                 req_out_q, req_out_d;
  logic [DW-1:0]        data_out_q, data_out_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 start;
  logic                 rtz_done;

  assign start    = (bus.mask != '0) && ((req_s & bus.mask) == bus.mask);
  assign rtz_done = ((req_s & mask_q) == '0) && !ack_s;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = REQ;
      REQ:     if (ack_s)    state_d = RTZ;
      RTZ:     if (rtz_done) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_comb begin
    mask_d     = mask_q;
    ack_in_d   = ack_in_q;
    req_out_d  = req_out_q;
    data_out_d = data_out_q;
    count_d    = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d     = bus.mask;
          data_out_d = data_masked;
          req_out_d  = 1'b1;
        end
      end
      REQ: begin
        if (ack_s) begin
          req_out_d = 1'b0;
          ack_in_d  = mask_q;
        end
      end
      RTZ: begin
        if (rtz_done) begin
          ack_in_d = '0;
          count_d  = count_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        // Unreachable encoding: drop everything and fall back to IDLE.
        mask_d     = '0;
        ack_in_d   = '0;
        req_out_d  = 1'b0;
        data_out_d = '0;
        count_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mask_q     <= '0;
      ack_in_q   <= '0;
      req_out_q  <= 1'b0;
      data_out_q <= '0;
      count_q    <= '0;
    end else begin
      mask_q     <= mask_d;
      ack_in_q   <= ack_in_d;
      req_out_q  <= req_out_d;
      data_out_q <= data_out_d;
      count_q    <= count_d;
    end
  end

  assign bus.ack_in   = ack_in_q;
  assign bus.req_out  = req_out_q;
  assign bus.data_out = data_out_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.count    = count_q;
endmodule
